data_mem_access_ctrl: RTL and testbench

//  Initiator-side controller for the single-port, synchronous-read data memory (WORD x LENGTH).

---
 rtl/data_mem_access_ctrl_if.sv | 31 +++
 rtl/data_mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_ctrl_if.sv
// Datapath-side handshake bundle for the data memory access controller:
// request channel, write-beat channel and read-beat channel plus busy status.
interface data_mem_access_ctrl_if #(
   parameter int WORD     = 16,
   parameter int ADDRESSL = 10,
   parameter int LENW     = 4
);
   logic                reqValid;
   logic                reqReady;
   logic                reqWrite;
   logic [ADDRESSL-1:0] reqAddress;
   logic [LENW-1:0]     reqLength;
   logic                wdataValid;
   logic                wdataReady;
   logic [WORD-1:0]     wdata;
   logic                rdataValid;
   logic                rdataReady;
   logic [WORD-1:0]     rdata;
   logic                rdataLast;
   logic                busy;

   modport slave (
      input  reqValid, reqWrite, reqAddress, reqLength, wdataValid, wdata, rdataReady,
      output reqReady, wdataReady, rdataValid, rdata, rdataLast, busy
   );

   modport master (
      output reqValid, reqWrite, reqAddress, reqLength, wdataValid, wdata, rdataReady,
      input  reqReady, wdataReady, rdataValid, rdata, rdataLast, busy
   );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Initiator-side controller for a single-port synchronous-read data memory:
// turns single/burst read/write requests into per-beat memory strobes.
module data_mem_access_ctrl #(
   parameter int WORD     = 16,
   parameter int ADDRESSL = 10,
   parameter int LENW     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_access_ctrl_if.slave dp,
   output logic [ADDRESSL-1:0]  memAddress,
   output logic [WORD-1:0]      memWriteData,
   output logic                 memRead,
   output logic                 memWrite,
   input  logic [WORD-1:0]      memReadData
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t              state_reg, state_next;
   logic [ADDRESSL-1:0] base_reg, base_next;
   logic [ADDRESSL-1:0] addr_hold_reg, addr_hold_next;
   logic [LENW-1:0]     len_reg, len_next;
   logic [LENW-1:0]     beat_reg, beat_next;
   logic                rvalid_reg, rvalid_next;
   logic                rlast_reg, rlast_next;

   logic [ADDRESSL-1:0] beat_addr;
   logic                beat_last;
   logic                issue;

   // Address arithmetic wraps naturally at ADDRESSL bits.
   assign beat_addr = base_reg + ADDRESSL'(beat_reg);
   assign beat_last = (beat_reg == len_reg);
   assign issue     = !rvalid_reg || dp.rdataReady;

   assign dp.rdataValid = rvalid_reg;
   assign dp.rdataLast  = rlast_reg;
   assign dp.rdata      = memReadData;
   assign dp.busy       = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         base_reg      <= '0;
         addr_hold_reg <= '0;
         len_reg       <= '0;
         beat_reg      <= '0;
         rvalid_reg    <= 1'b0;
         rlast_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         base_reg      <= base_next;
         addr_hold_reg <= addr_hold_next;
         len_reg       <= len_next;
         beat_reg      <= beat_next;
         rvalid_reg    <= rvalid_next;
         rlast_reg     <= rlast_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      base_next      = base_reg;
      addr_hold_next = addr_hold_reg;
      len_next       = len_reg;
      beat_next      = beat_reg;
      rvalid_next    = rvalid_reg;
      rlast_next     = rlast_reg;
      dp.reqReady    = 1'b0;
      dp.wdataReady  = 1'b0;
      memRead        = 1'b0;
      memWrite       = 1'b0;
      memAddress     = addr_hold_reg;
      memWriteData   = '0;

      case (state_reg)
         IDLE: begin
            dp.reqReady = 1'b1;
            if (dp.reqValid) begin
               base_next  = dp.reqAddress;
               len_next   = dp.reqLength;
               beat_next  = '0;
               state_next = dp.reqWrite ? WRITE : READ;
            end
         end
         WRITE: begin
            dp.wdataReady  = 1'b1;
            memAddress     = beat_addr;
            memWriteData   = dp.wdata;
            memWrite       = dp.wdataValid;
            addr_hold_next = beat_addr;
            if (dp.wdataValid) begin
               beat_next = beat_reg + 1'b1;
               if (beat_last)
                  state_next = IDLE;
            end
         end
         READ: begin
            // Issue only when the output slot is empty or being drained this cycle.
            memAddress     = beat_addr;
            memRead        = issue;
            addr_hold_next = beat_addr;
            if (issue) begin
               beat_next   = beat_reg + 1'b1;
               rvalid_next = 1'b1;
               rlast_next  = beat_last;
               if (beat_last)
                  state_next = DRAIN;
            end else if (dp.rdataReady) begin
               rvalid_next = 1'b0;
            end
         end
         DRAIN: begin
            if (rvalid_reg && dp.rdataReady) begin
               rvalid_next = 1'b0;
               rlast_next  = 1'b0;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Scoreboard bench: stimulus pushes expected writes/read beats; a negedge monitor pops and compares.
module tb_data_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  memAddress;
   logic [15:0] memWriteData;
   logic        memRead;
   logic        memWrite;
   logic [15:0] memReadData;

   data_mem_access_ctrl_if #(.WORD(16), .ADDRESSL(10), .LENW(4)) dif ();

   data_mem_access_ctrl #(.WORD(16), .ADDRESSL(10), .LENW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dp           (dif),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memReadData  (memReadData)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: readData only changes on a memRead cycle.
   logic [15:0] mem [1024];
   always @(posedge clk) begin
      if (memWrite) mem[memAddress] <= memWriteData;
      if (memRead)  memReadData     <= mem[memAddress];
   end

   typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
   typedef struct { logic [15:0] d; logic l; } rd_t;
   wr_t wq[$];
   rd_t rq[$];

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [15:0] dbuf [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor
   logic        stall_prev = 1'b0;
   logic [15:0] stall_data = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (memRead && memWrite) chk("rd_wr_overlap", 1, 0);
         if (memWrite) begin
            chk("wr_only_when_valid", dif.wdataValid, 1);
            wr_count++;
            if (wq.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               wr_t e;
               e = wq.pop_front();
               $display("WR addr=%03h data=%04h exp_addr=%03h exp_data=%04h", memAddress, memWriteData, e.a, e.d);
               chk("wr_addr", memAddress, e.a);
               chk("wr_data", memWriteData, e.d);
            end
         end
         if (stall_prev && dif.rdataValid) chk("rd_stable", dif.rdata, stall_data);
         if (dif.rdataValid && dif.rdataReady) begin
            if (rq.size() == 0) begin
               chk("unexpected_read", 1, 0);
            end else begin
               rd_t e;
               e = rq.pop_front();
               $display("RD data=%04h last=%0d exp_data=%04h exp_last=%0d", dif.rdata, dif.rdataLast, e.d, e.l);
               chk("rd_data", dif.rdata, e.d);
               chk("rd_last", dif.rdataLast, e.l);
            end
         end
         stall_prev = dif.rdataValid && !dif.rdataReady;
         stall_data = dif.rdata;
      end
   end

   task automatic send_req(input logic wr, input logic [9:0] a, input logic [3:0] len);
      int ok = 0;
      @(posedge clk); #1;
      dif.reqValid = 1'b1; dif.reqWrite = wr; dif.reqAddress = a; dif.reqLength = len;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (dif.reqReady) begin ok = 1; break; end
      end
      if (ok == 0) chk("req_timeout", 0, 1);
      @(posedge clk); #1;
      dif.reqValid = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [3:0] len, input logic [31:0] vmask);
      int beats = 0;
      logic acc;
      for (int i = 0; i <= int'(len); i++) wq.push_back('{a: 10'(a + 10'(i)), d: dbuf[i]});
      send_req(1'b1, a, len);
      for (int c = 0; c < 200; c++) begin
         dif.wdataValid = vmask[c % 32];
         dif.wdata      = dbuf[beats];
         @(negedge clk);
         acc = dif.wdataValid && dif.wdataReady;
         @(posedge clk); #1;
         if (acc) beats++;
         if (beats == int'(len) + 1) break;
      end
      dif.wdataValid = 1'b0;
      chk("wr_beats", beats, int'(len) + 1);
      chk("wr_idle_after", dif.busy, 0);
   endtask

   task automatic do_read(input logic [9:0] a, input logic [3:0] len, input int mode, input int check_lat);
      int k = 0;
      for (int i = 0; i <= int'(len); i++) rq.push_back('{d: dbuf[i], l: (i == int'(len))});
      send_req(1'b0, a, len);
      while (k < 200) begin
         dif.rdataReady = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         @(negedge clk);
         if (check_lat != 0 && k == 0) chk("lat_cycle1_valid", dif.rdataValid, 0);
         if (check_lat != 0 && k == 1) chk("lat_cycle2_valid", dif.rdataValid, 1);
         @(posedge clk); #1;
         k++;
         if (rq.size() == 0) break;
      end
      chk("rd_queue_empty", rq.size(), 0);
      chk("rd_idle_after", dif.busy, 0);
      dif.rdataReady = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      dif.reqValid = 0; dif.reqWrite = 0; dif.reqAddress = '0; dif.reqLength = '0;
      dif.wdataValid = 0; dif.wdata = '0; dif.rdataReady = 0;
      #12;
      chk("rst_reqReady", dif.reqReady, 1);
      chk("rst_busy", dif.busy, 0);
      chk("rst_rdataValid", dif.rdataValid, 0);
      chk("rst_rdataLast", dif.rdataLast, 0);
      chk("rst_wdataReady", dif.wdataReady, 0);
      chk("rst_memRead", memRead, 0);
      chk("rst_memWrite", memWrite, 0);
      chk("rst_memAddress", memAddress, 0);
      chk("rst_memWriteData", memWriteData, 0);
      #20 rst_n = 1'b1;

      // 1: single write then single read at 0x005
      dbuf[0] = 16'hBEEF;
      wr_count = 0;
      do_write(10'h005, 4'd0, 32'hFFFF_FFFF);
      chk("t1_wr_count", wr_count, 1);
      do_read(10'h005, 4'd0, 0, 1);

      // 2: wrapping burst write and readback
      dbuf[0] = 16'h0001; dbuf[1] = 16'h0002; dbuf[2] = 16'h0003; dbuf[3] = 16'h0004;
      do_write(10'h3FE, 4'd3, 32'hFFFF_FFFF);
      do_read(10'h3FE, 4'd3, 0, 0);

      // 3: 8-beat burst, read back with ready pattern 1,0,0,1,...
      for (int i = 0; i < 8; i++) dbuf[i] = 16'h1000 + 16'(i);
      do_write(10'h100, 4'd7, 32'hFFFF_FFFF);
      do_read(10'h100, 4'd7, 1, 0);

      // 4: write burst with wdataValid gaps 1,0,1,0,0,1,1
      dbuf[0] = 16'h00A0; dbuf[1] = 16'h00A1; dbuf[2] = 16'h00A2; dbuf[3] = 16'h00A3;
      wr_count = 0;
      do_write(10'h200, 4'd3, 32'h0000_0065);
      chk("t4_wr_count", wr_count, 4);
      do_read(10'h200, 4'd3, 0, 0);

      // 5: async reset after 3 read beats
      for (int i = 0; i < 8; i++) rq.push_back('{d: 16'h1000 + 16'(i), l: (i == 7)});
      dif.rdataReady = 1'b1;
      send_req(1'b0, 10'h100, 4'd7);
      cyc = 0;
      while (rq.size() > 5 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_three_beats", rq.size(), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_rdataValid", dif.rdataValid, 0);
      chk("t5_rst_rdataLast", dif.rdataLast, 0);
      chk("t5_rst_busy", dif.busy, 0);
      chk("t5_rst_memRead", memRead, 0);
      chk("t5_rst_memAddress", memAddress, 0);
      rq.delete();
      dif.rdataReady = 1'b0;
      @(negedge clk);
      chk("t5_rst_hold_memRead", memRead, 0);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_reqReady_after", dif.reqReady, 1);
      chk("t5_busy_after", dif.busy, 0);

      // 6: back-to-back reads with reqValid held
      rq.push_back('{d: 16'hBEEF, l: 1'b1});
      rq.push_back('{d: 16'h0001, l: 1'b1});
      dif.rdataReady = 1'b1;
      send_req(1'b0, 10'h005, 4'd0);
      dif.reqValid = 1'b1; dif.reqWrite = 1'b0; dif.reqAddress = 10'h3FE; dif.reqLength = 4'd0;
      cyc = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         cyc++;
         if (dif.reqReady) break;
      end
      chk("t6_b2b_gap", cyc, 3);
      @(posedge clk); #1;
      dif.reqValid = 1'b0;
      cyc = 0;
      while ((rq.size() != 0 || dif.busy) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t6_queue_empty", rq.size(), 0);
      chk("t6_idle", dif.busy, 0);

      chk("final_wq_empty", wq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
